// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the memory handshakes and decides in which
// cycle the IR, PC, register-file and data-memory enables fire.
module multicycle_sequencer #(
    parameter logic [6:0] OP_R  = 7'b1110011,
    parameter logic [6:0] OP_LD = 7'b1101011,
    parameter logic [6:0] OP_ST = 7'b1000011,
    parameter logic [6:0] OP_BR = 7'b1100011,
    parameter int         CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             trap,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    // Instruction class captured in DECODE; reset value 0 is the R class.
    localparam logic [1:0] CLS_R  = 2'd0;
    localparam logic [1:0] CLS_LD = 2'd1;
    localparam logic [1:0] CLS_ST = 2'd2;
    localparam logic [1:0] CLS_BR = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       cls_q, cls_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             trap_q, trap_d;
    logic             complete;

    // State, class, retired counter and sticky trap flag; async reset clears all.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_R;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            retired_q <= retired_d;
            trap_q    <= trap_d;
        end
    end

    // Next-state and combinational enable decode; every enable defaults low.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        retired_d = retired_q;
        trap_d    = trap_q;
        imem_req  = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        complete  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ack;
                if (imem_ack) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Opcode is only looked at here; later changes are ignored.
                state_d = S_EXEC;
                if (opcode == OP_R)       cls_d = CLS_R;
                else if (opcode == OP_LD) cls_d = CLS_LD;
                else if (opcode == OP_ST) cls_d = CLS_ST;
                else if (opcode == OP_BR) cls_d = CLS_BR;
                else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_R:          state_d = S_WB;
                    CLS_LD, CLS_ST: state_d = S_MEM;
                    default: begin
                        // Branch resolves here: zero selects the target.
                        pc_write = 1'b1;
                        pc_src   = zero;
                        complete = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (cls_q == CLS_LD);
                mem_write = (cls_q == CLS_ST);
                if (dmem_ack) begin
                    if (cls_q == CLS_LD) begin
                        state_d = S_WB;
                    end else begin
                        pc_write = 1'b1;
                        complete = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                complete  = 1'b1;
            end
            S_TRAP: begin
                // Parked until reset; counter and enables frozen.
                state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase

        // Completion: count it and either chain the next fetch or go idle.
        if (complete) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = run ? S_FETCH : S_IDLE;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign trap    = trap_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle control sequencer for the Lab5 processor datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It issues request/acknowledge handshakes to instruction and data memory and generates the IR, PC, register-file and memory enables. It sits above Control_Logic: Control_Logic still decodes fields, immediates and ALU_Control, while this block decides in which cycle each enable fires.

## Interface
Parameters:
- OP_R, 7'b1110011, R-type ALU opcode
- OP_LD, 7'b1101011, load opcode
- OP_ST, 7'b1000011, store opcode
- OP_BR, 7'b1100011, branch opcode
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; asynchronous, active-low (rst=0 resets)
- run  in  1  level; permits starting a new instruction
- opcode  in  7  ReadInstruction[6:0] from the IR
- zero  in  1  ALU zero flag; branch taken when 1
- imem_ack  in  1  instruction memory has data this cycle
- dmem_ack  in  1  data memory access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR
- dmem_req  out  1  data memory request
- mem_read  out  1  data read strobe
- mem_write  out  1  data write strobe
- reg_write  out  1  register file write enable
- pc_write  out  1  PC update enable
- pc_src  out  1  0 = PC+4, 1 = branch target
- trap  out  1  illegal opcode seen (sticky)
- state  out  3  current state encoding
- retired  out  CNT_W  completed-instruction count

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6. Codes 7 and up are unreachable and recover to IDLE.
- IDLE: moves to FETCH when run=1.
- FETCH:
  - imem_req=1.
  - ir_write = imem_ack.
  - On imem_ack=1, moves to DECODE; otherwise holds.
- DECODE:
  - Latches the opcode class into an internal 2-bit register.
  - R, LD, ST or BR → EXEC.
  - Any other opcode → TRAP.
- EXEC:
  - R and LD → next state is WB for R, MEM for LD.
  - ST → MEM.
  - BR: pc_write=1 and pc_src=zero; the instruction completes here.
- MEM:
  - dmem_req=1 throughout.
  - mem_read=1 for LD; mem_write=1 for ST.
  - On dmem_ack=1: LD → WB; ST completes with pc_write=1 and pc_src=0.
  - Otherwise holds.
- WB: reg_write=1, pc_write=1, pc_src=0; the instruction completes.
- Completion (any of the cycles above):
  - retired increments by 1 and wraps at 2^CNT_W.
  - Next state is FETCH if run=1, else IDLE.
  - Dropping run mid-instruction never aborts it.
- TRAP: trap=1. All enables stay 0 and the counter is frozen. Only reset exits TRAP.
- Enable rules:
  - All enables are zero in any state where this list does not assert them.
  - pc_write is asserted at most once per instruction.
  - reg_write and mem_write are never high together.

## Timing
- Reset value while rst=0: state=IDLE, class register 0, retired=0, trap=0, all enables 0, pc_src=0.
- state, the class register, retired and trap are registers. All other outputs decode combinationally from state, the class register, imem_ack, dmem_ack and zero.
- Reset asserted mid-instruction:
  - All outputs reach their reset values immediately, without waiting for a clock edge.
  - Any outstanding memory request is dropped, with no completion.
- Latency in cycles from FETCH entry to completion, with acks high on first request:
  - BR: 3
  - R: 4
  - ST: 4
  - LD: 5
- Each cycle an ack is held low adds exactly one cycle.
- imem_ack is ignored outside FETCH; dmem_ack is ignored outside MEM.
- The opcode input is sampled only in DECODE; changes at other times have no effect.
- zero is sampled only in EXEC for BR.

## Test plan
- Reset/IDLE: rst=0 at t0, release with run=0 → state=0, all enables 0, retired=0. Then set run=1 → state=1 and imem_req=1 on the next edge.
- R-type, zero-wait: opcode=7'b1110011, imem_ack=dmem_ack=1, run=1 → state sequence 1,2,3,5,1; reg_write and pc_write high only in state 5; retired=1 after 4 cycles.
- Load with waits: opcode=7'b1101011, dmem_ack low for 3 MEM cycles → mem_read=1 and dmem_req=1 for 4 cycles, then WB with reg_write=1; total 8 cycles; mem_write never 1.
- Branch taken and not taken:
  - opcode=7'b1100011, zero=1 in EXEC → pc_write=1, pc_src=1; sequence 1,2,3,1.
  - Repeat with zero=0 → pc_src=0.
- Illegal opcode and stop:
  - opcode=7'b0011111 → TRAP (state=6) after DECODE; trap stays 1 and retired stays constant for 20 cycles despite acks.
  - Separately, run=0 during a store's MEM → store completes, then state=0.
- Async reset mid-load: pull rst low while in MEM → dmem_req and mem_read drop immediately and state=0 before the next edge. The counter wrap is checked with CNT_W=4: 16 completions → retired=0.
